des_round_f_ctrl: RTL
=====================

Name: des_round_f_ctrl

Overview:
- Feistel f-function controller for one DES round.
- Upstream half: accepts R(i-1), L(i-1) and the 48-bit round subkey, then drives the eight S-box instances (S1..S8) with E(R) XOR K and their select lines.
- Downstream half: collects the eight 4-bit S-box results and applies the P permutation, producing f and R(i) = L XOR f.
- Sits between the key schedule/round sequencer and the S_Box_S1..S8 instances.

Parameters:
- TIMEOUT_CYCLES, 4: maximum cycles select stays high waiting for all eight finish flags before an error is raised.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  round operands valid
- in_ready  out  1  block can accept operands; high only in IDLE
- in_l  in  32  L(i-1); DES bit 1 = vector MSB
- in_r  in  32  R(i-1)
- in_subkey  in  48  K(i)
- sbox_input  out  48  six bits per S-box; S1 = [48:43], ..., S8 = [6:1]
- sbox_select  out  8  one bit per S-box; bit 8 = S1
- sbox_output  in  32  four bits per S-box; S1 = [32:29], ..., S8 = [4:1]
- sbox_finish  in  8  per-S-box finish flags; bit 8 = S1
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts the result
- out_f  out  32  P(S1..S8)
- out_r_next  out  32  in_l XOR out_f
- err_timeout  out  1  sticky; set when a timeout occurs

Behaviour:
- Reset (synchronous): state IDLE; in_ready=1; sbox_select=0; out_valid=0; out_f=0; out_r_next=0; err_timeout=0; mix, L and timeout-counter registers=0.
- Reset asserted mid-operation aborts the operation: select drops on the next edge and any captured result is discarded.
- State IDLE:
  - On in_valid & in_ready, register mix <= E(in_r) XOR in_subkey and l_reg <= in_l.
  - Go to SELECT.
- State SELECT:
  - sbox_input = mix; sbox_select = 8'hFF (held); counter cleared.
  - Go to WAIT next cycle.
- State WAIT:
  - sbox_select stays 8'hFF and sbox_input stays stable.
  - When sbox_finish == 8'hFF: register out_f <= P(sbox_output) and out_r_next <= l_reg XOR P(sbox_output); drop select; go to DONE.
  - A partial finish pattern is ignored; the block keeps waiting.
  - The counter increments every WAIT cycle. If it reaches TIMEOUT_CYCLES without a full finish: set err_timeout, drop select, return to IDLE, produce no output.
- State DONE:
  - out_valid=1; out_f and out_r_next stay stable.
  - On out_ready: out_valid drops on the next edge and the state returns to IDLE.
  - in_ready stays low throughout DONE, so operands cannot be accepted in the same cycle as the result is taken.
- Latency with a 1-cycle S-box:
  - Accept at cycle 0, select high at cycles 1–2.
  - Finish seen at cycle 2, out_valid at cycle 3.
  - Throughput is one round per 4 cycles when out_ready is tied high.
- in_valid outside IDLE is ignored; operands are not sampled.
- err_timeout clears only on rst.
- sbox_output is never sampled unless all finish flags are high, so X values from the idle S-boxes never propagate.

Decomposition:
- Package des_pkg:
  - E expansion table (48 entries) and P permutation table (32 entries), in DES 1-based numbering.
  - Mapping rule: DES bit i ↔ vector index (width+1−i).
  - State enum {IDLE, SELECT, WAIT, DONE}.
  - Constant SBOX_COUNT=8.
- One sub-module, des_perm_e_p: purely combinational E-expand and P-permute, reused by the key-mixing and collection paths.
- The FSM, counter and registers stay in des_round_f_ctrl.

Test Plan:
- Known vector:
  - Stimulus: in_l=CC00CCFF, in_r=F0AAF0AA, in_subkey=1B02EFFC7072, with S1..S8 instances attached.
  - Required: sbox_input=6117BA866527, sbox_output seen=5C82B597, out_f=234AA9BB, out_r_next=EF4A6544, out_valid at cycle 3.
- Back-pressure:
  - Stimulus: same vector, out_ready low for 5 cycles.
  - Required: out_valid and the data held stable; in_ready low; a second in_valid is ignored. When out_ready rises, out_valid drops next cycle and in_ready=1.
- Timeout:
  - Stimulus: S-box model ties sbox_finish=8'h7F.
  - Required: err_timeout=1 after 4 WAIT cycles; select returns to 0; out_valid is never asserted; in_ready=1.
- Reset mid-operation:
  - Stimulus: rst asserted in the WAIT cycle.
  - Required: the next cycle shows all outputs at reset values and no out_valid; a following known-vector run gives correct results.
- Delayed S-box:
  - Stimulus: a model whose finish arrives 3 cycles after select, with staggered per-box flags.
  - Required: the capture occurs only on the cycle when all eight flags are high; out_f is correct; no timeout.
- Back-to-back:
  - Stimulus: 16 rounds, out_ready=1.
  - Required: each result matches the reference model; one result every 4 cycles.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES constants for the round f-function controller: E and P tables in
// DES 1-based numbering (DES bit i lives at vector index width-i) and the FSM states.
package des_pkg;

  localparam int SBOX_COUNT = 8;
  localparam int HALF_W     = 32;
  localparam int EXP_W      = 48;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    WAIT,
    DONE
  } round_state_e;

  // Entry n gives the source DES bit for output DES bit n+1.
  localparam int unsigned E_TABLE [EXP_W] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int unsigned P_TABLE [HALF_W] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

endpackage

// File: rtl/des_perm_e_p.sv
// Combinational DES E-expansion (32 -> 48) and P-permutation (32 -> 32),
// shared by the key-mixing and result-collection paths of the round controller.
module des_perm_e_p
  import des_pkg::*;
(
  input  logic [HALF_W-1:0] expand_src,
  output logic [EXP_W-1:0]  expand_dst,
  input  logic [HALF_W-1:0] perm_src,
  output logic [HALF_W-1:0] perm_dst
);

  // NOTE: pure wiring through continuous assigns; with no procedural block there is no path to a latch.
  for (genvar i = 0; i < EXP_W; i++) begin : g_expand
    assign expand_dst[EXP_W-1-i] = expand_src[HALF_W - E_TABLE[i]];
  end

  for (genvar i = 0; i < HALF_W; i++) begin : g_perm
    assign perm_dst[HALF_W-1-i] = perm_src[HALF_W - P_TABLE[i]];
  end

endmodule

// File: rtl/des_round_f_ctrl.sv
// Feistel f-function controller for one DES round: mixes E(R) with the subkey,
// drives the eight S-boxes, then permutes their result into f and R(i) = L ^ f.
module des_round_f_ctrl
  import des_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [HALF_W-1:0]       in_l,
  input  logic [HALF_W-1:0]       in_r,
  input  logic [EXP_W-1:0]        in_subkey,
  output logic [EXP_W-1:0]        sbox_input,
  output logic [SBOX_COUNT-1:0]   sbox_select,
  input  logic [HALF_W-1:0]       sbox_output,
  input  logic [SBOX_COUNT-1:0]   sbox_finish,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [HALF_W-1:0]       out_f,
  output logic [HALF_W-1:0]       out_r_next,
  output logic                    err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  round_state_e      state;
  logic [EXP_W-1:0]  mix;
  logic [HALF_W-1:0] l_reg;
  logic [CNT_W-1:0]  wait_cnt;
  logic [EXP_W-1:0]  e_of_r;
  logic [HALF_W-1:0] p_of_s;

  des_perm_e_p u_perm (
    .expand_src (in_r),
    .expand_dst (e_of_r),
    .perm_src   (sbox_output),
    .perm_dst   (p_of_s)
  );

  // mix only changes on acceptance, so the S-box operands stay stable while selected.
  assign sbox_input = mix;

  // NOTE: sequential state uses non-blocking assignments so every branch sees pre-edge register values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      sbox_select <= '0;
      out_valid   <= 1'b0;
      out_f       <= '0;
      out_r_next  <= '0;
      err_timeout <= 1'b0;
      mix         <= '0;
      l_reg       <= '0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mix         <= e_of_r ^ in_subkey;
            l_reg       <= in_l;
            in_ready    <= 1'b0;
            sbox_select <= '1;
            state       <= SELECT;
          end
        end
        SELECT: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // sbox_output is only sampled once every box reports finish.
          if (&sbox_finish) begin
            out_f       <= p_of_s;
            out_r_next  <= l_reg ^ p_of_s;
            sbox_select <= '0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            err_timeout <= 1'b1;
            sbox_select <= '0;
            in_ready    <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
